mem_access_stage: RTL and testbench

- Memory-stage consumer of the EXE/MEM pipeline register. It decodes the latched control word and runs load/store transactions on the data-memory req/ack interface.
- Drives the register's active-low load enable (high = hold) while a transaction is outstanding.
- Produces the registered MEM/WB write-back bundle.

---
 rtl/mem_access_stage.sv | 240 ++++++++++++++++++++++++
 tb/tb_mem_access_stage.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// mem_access_stage
// ----------------
// Memory stage of the pipeline. Consumes the EXE/MEM register contents,
// runs load/store transactions on the data-memory req/ack handshake and
// produces the registered MEM/WB write-back bundle.
//
// Ports
//   clk, rst_n          clock (rising edge) / asynchronous active-low reset
//   i_ctrl[15:0]        control word: [0] mem_read, [1] mem_write,
//                       [2] reg_write, [3] mem_to_reg, [15:4] pass-through
//   i_srcReg[31:0]      store data
//   i_srcRegDir[3:0]    destination register index
//   i_alu[31:0]         ALU result / memory address
//   i_Robj[31:0]        auxiliary operand, forwarded to WB unchanged
//   o_stall             to EXE/MEM load enable; 1 = hold register contents
//   dmem_req/we/addr/wdata, dmem_rdata/ack   data-memory interface
//   o_wb_en/dir/data/ctrl/aux                registered write-back bundle
//   o_err               sticky access-timeout flag
//
// Build option
//   MEM_TIMEOUT_EN  when defined, an access that sees no dmem_ack within
//                   TIMEOUT cycles is abandoned and o_err is set. When
//                   undefined, ACCESS waits indefinitely and o_err is 0.

module mem_access_stage #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [15:0]       i_ctrl,
  input  logic [31:0]       i_srcReg,
  input  logic [3:0]        i_srcRegDir,
  input  logic [31:0]       i_alu,
  input  logic [31:0]       i_Robj,
  output logic              o_stall,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  input  logic [31:0]       dmem_rdata,
  input  logic              dmem_ack,
  output logic              o_wb_en,
  output logic [3:0]        o_wb_dir,
  output logic [31:0]       o_wb_data,
  output logic [15:0]       o_wb_ctrl,
  output logic [31:0]       o_wb_aux,
  output logic              o_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                stall_q, stall_d;
  logic                req_q, req_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;

  // Transaction context captured when the request is issued; the EXE/MEM
  // register may already hold a different instruction by then.
  logic [31:0]         alu_q, alu_d;
  logic [15:0]         ctrl_q, ctrl_d;
  logic [3:0]          dir_q, dir_d;
  logic [31:0]         aux_q, aux_d;

  logic                wb_en_q, wb_en_d;
  logic [3:0]          wb_dir_q, wb_dir_d;
  logic [31:0]         wb_data_q, wb_data_d;
  logic [15:0]         wb_ctrl_q, wb_ctrl_d;
  logic [31:0]         wb_aux_q, wb_aux_d;

  logic                is_mem_op;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                err_q, err_d;
  logic                timeout_hit;

  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));
`endif

  assign is_mem_op = i_ctrl[0] | i_ctrl[1];

  always_comb begin
    state_d   = state_q;
    stall_d   = stall_q;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    alu_d     = alu_q;
    ctrl_d    = ctrl_q;
    dir_d     = dir_q;
    aux_d     = aux_q;
    wb_en_d   = 1'b0;
    wb_dir_d  = wb_dir_q;
    wb_data_d = wb_data_q;
    wb_ctrl_d = wb_ctrl_q;
    wb_aux_d  = wb_aux_q;
`ifdef MEM_TIMEOUT_EN
    cnt_d     = cnt_q;
    err_d     = err_q;
`endif

    case (state_q)
      IDLE: begin
        if (is_mem_op) begin
          addr_d  = i_alu[ADDR_W-1:0];
          wdata_d = i_srcReg;
          alu_d   = i_alu;
          ctrl_d  = i_ctrl;
          dir_d   = i_srcRegDir;
          aux_d   = i_Robj;
          req_d   = 1'b1;
          // Read wins when both read and write are flagged.
          we_d    = i_ctrl[1] & ~i_ctrl[0];
          stall_d = 1'b1;
          state_d = ACCESS;
`ifdef MEM_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end else begin
          wb_en_d   = i_ctrl[2];
          wb_data_d = i_alu;
          wb_dir_d  = i_srcRegDir;
          wb_ctrl_d = i_ctrl;
          wb_aux_d  = i_Robj;
        end
      end

      ACCESS: begin
        if (dmem_ack) begin
          req_d     = 1'b0;
          stall_d   = 1'b0;
          state_d   = RESP;
          wb_en_d   = ctrl_q[2];
          // Only a load with mem_to_reg returns memory data.
          wb_data_d = (ctrl_q[0] & ctrl_q[3]) ? dmem_rdata : alu_q;
          wb_dir_d  = dir_q;
          wb_ctrl_d = ctrl_q;
          wb_aux_d  = aux_q;
        end
`ifdef MEM_TIMEOUT_EN
        else if (timeout_hit) begin
          // Abandon the access: the pipeline resumes without a write-back.
          req_d     = 1'b0;
          stall_d   = 1'b0;
          err_d     = 1'b1;
          state_d   = RESP;
          wb_data_d = alu_q;
          wb_dir_d  = dir_q;
          wb_ctrl_d = ctrl_q;
          wb_aux_d  = aux_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end

      RESP: begin
        // EXE/MEM reloads on this edge; the new op is evaluated from IDLE.
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
        stall_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      stall_q   <= 1'b0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      alu_q     <= '0;
      ctrl_q    <= '0;
      dir_q     <= '0;
      aux_q     <= '0;
      wb_en_q   <= 1'b0;
      wb_dir_q  <= '0;
      wb_data_q <= '0;
      wb_ctrl_q <= '0;
      wb_aux_q  <= '0;
`ifdef MEM_TIMEOUT_EN
      cnt_q     <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      stall_q   <= stall_d;
      req_q     <= req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      alu_q     <= alu_d;
      ctrl_q    <= ctrl_d;
      dir_q     <= dir_d;
      aux_q     <= aux_d;
      wb_en_q   <= wb_en_d;
      wb_dir_q  <= wb_dir_d;
      wb_data_q <= wb_data_d;
      wb_ctrl_q <= wb_ctrl_d;
      wb_aux_q  <= wb_aux_d;
`ifdef MEM_TIMEOUT_EN
      cnt_q     <= cnt_d;
      err_q     <= err_d;
`endif
    end
  end

  assign o_stall    = stall_q;
  assign dmem_req   = req_q;
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_wdata = wdata_q;
  assign o_wb_en    = wb_en_q;
  assign o_wb_dir   = wb_dir_q;
  assign o_wb_data  = wb_data_q;
  assign o_wb_ctrl  = wb_ctrl_q;
  assign o_wb_aux   = wb_aux_q;

`ifdef MEM_TIMEOUT_EN
  assign o_err = err_q;
`else
  assign o_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed testbench for mem_access_stage (ADDR_W=16 to exercise the
// address truncation, TIMEOUT=8). Inputs are driven and outputs sampled
// on the falling edge.

module tb_mem_access_stage;

  localparam int ADDR_W  = 16;
  localparam int TIMEOUT = 8;

  logic              clk;
  logic              rst_n;
  logic [15:0]       i_ctrl;
  logic [31:0]       i_srcReg;
  logic [3:0]        i_srcRegDir;
  logic [31:0]       i_alu;
  logic [31:0]       i_Robj;
  logic              o_stall;
  logic              dmem_req;
  logic              dmem_we;
  logic [ADDR_W-1:0] dmem_addr;
  logic [31:0]       dmem_wdata;
  logic [31:0]       dmem_rdata;
  logic              dmem_ack;
  logic              o_wb_en;
  logic [3:0]        o_wb_dir;
  logic [31:0]       o_wb_data;
  logic [15:0]       o_wb_ctrl;
  logic [31:0]       o_wb_aux;
  logic              o_err;

  int n_compared;
  int n_mismatched;

  mem_access_stage #(
    .ADDR_W (ADDR_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_ctrl     (i_ctrl),
    .i_srcReg   (i_srcReg),
    .i_srcRegDir(i_srcRegDir),
    .i_alu      (i_alu),
    .i_Robj     (i_Robj),
    .o_stall    (o_stall),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_rdata (dmem_rdata),
    .dmem_ack   (dmem_ack),
    .o_wb_en    (o_wb_en),
    .o_wb_dir   (o_wb_dir),
    .o_wb_data  (o_wb_data),
    .o_wb_ctrl  (o_wb_ctrl),
    .o_wb_aux   (o_wb_aux),
    .o_err      (o_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic drive(input logic [15:0] ctrl, input logic [31:0] alu,
                       input logic [3:0] dir, input logic [31:0] src,
                       input logic [31:0] robj);
    i_ctrl      = ctrl;
    i_alu       = alu;
    i_srcRegDir = dir;
    i_srcReg    = src;
    i_Robj      = robj;
  endtask

  task automatic nop();
    drive(16'h0000, 32'h0, 4'h0, 32'h0, 32'h0);
  endtask

  int req_cycles;
  int wb_seen;

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    rst_n        = 1'b0;
    dmem_ack     = 1'b0;
    dmem_rdata   = 32'h0;
    nop();

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check_eq("rst_stall", 32'(o_stall), 32'h0);
    check_eq("rst_req",   32'(dmem_req), 32'h0);
    check_eq("rst_we",    32'(dmem_we), 32'h0);
    check_eq("rst_addr",  32'(dmem_addr), 32'h0);
    check_eq("rst_wdata", dmem_wdata, 32'h0);
    check_eq("rst_wb_en", 32'(o_wb_en), 32'h0);
    check_eq("rst_wb_data", o_wb_data, 32'h0);
    check_eq("rst_err",   32'(o_err), 32'h0);
    rst_n = 1'b1;

    // ALU op: latency 1, no stall
    drive(16'h0004, 32'h0000_1234, 4'd5, 32'h0, 32'hA5A5_0001);
    @(negedge clk);
    check_eq("alu_wb_en",   32'(o_wb_en), 32'h1);
    check_eq("alu_wb_dir",  32'(o_wb_dir), 32'h5);
    check_eq("alu_wb_data", o_wb_data, 32'h0000_1234);
    check_eq("alu_wb_aux",  o_wb_aux, 32'hA5A5_0001);
    check_eq("alu_wb_ctrl", 32'(o_wb_ctrl), 32'h0004);
    check_eq("alu_stall",   32'(o_stall), 32'h0);
    nop();
    // Stray ack in IDLE must be ignored
    dmem_ack   = 1'b1;
    dmem_rdata = 32'h1111_2222;
    @(negedge clk);
    dmem_ack = 1'b0;
    check_eq("idle_ack_wb_en", 32'(o_wb_en), 32'h0);
    check_eq("idle_ack_req",   32'(dmem_req), 32'h0);

    // Load, ack after 3 request cycles; upper address bits dropped
    drive(16'h000D, 32'h1234_0040, 4'd7, 32'h0, 32'h0);
    @(negedge clk);
    nop();
    check_eq("ld_req_c1",   32'(dmem_req), 32'h1);
    check_eq("ld_stall_c1", 32'(o_stall), 32'h1);
    check_eq("ld_addr",     32'(dmem_addr), 32'h0000_0040);
    check_eq("ld_we",       32'(dmem_we), 32'h0);
    check_eq("ld_wb_en_c1", 32'(o_wb_en), 32'h0);
    @(negedge clk);
    check_eq("ld_req_c2",   32'(dmem_req), 32'h1);
    @(negedge clk);
    check_eq("ld_req_c3",   32'(dmem_req), 32'h1);
    check_eq("ld_stall_c3", 32'(o_stall), 32'h1);
    dmem_ack   = 1'b1;
    dmem_rdata = 32'hCAFE_BABE;
    @(negedge clk);
    dmem_ack = 1'b0;
    check_eq("ld_req_resp",   32'(dmem_req), 32'h0);
    check_eq("ld_stall_resp", 32'(o_stall), 32'h0);
    check_eq("ld_wb_en",      32'(o_wb_en), 32'h1);
    check_eq("ld_wb_data",    o_wb_data, 32'hCAFE_BABE);
    check_eq("ld_wb_dir",     32'(o_wb_dir), 32'h7);
    @(negedge clk);
    check_eq("ld_wb_en_once", 32'(o_wb_en), 32'h0);

    // Store with ack in the first request cycle
    drive(16'h0002, 32'h0000_0080, 4'd1, 32'hDEAD_BEEF, 32'h0);
    @(negedge clk);
    nop();
    check_eq("st_req",   32'(dmem_req), 32'h1);
    check_eq("st_we",    32'(dmem_we), 32'h1);
    check_eq("st_wdata", dmem_wdata, 32'hDEAD_BEEF);
    check_eq("st_addr",  32'(dmem_addr), 32'h0000_0080);
    dmem_ack = 1'b1;
    @(negedge clk);
    dmem_ack = 1'b0;
    check_eq("st_req_drop", 32'(dmem_req), 32'h0);
    check_eq("st_stall",    32'(o_stall), 32'h0);
    check_eq("st_wb_en",    32'(o_wb_en), 32'h0);
    check_eq("st_wb_data",  o_wb_data, 32'h0000_0080);
    @(negedge clk);

    // Back-to-back: load then store already waiting in EXE/MEM
    drive(16'h000D, 32'h0000_0100, 4'd3, 32'h1111_1111, 32'h0);
    @(negedge clk);
    check_eq("b2b_req1",  32'(dmem_req), 32'h1);
    drive(16'h0002, 32'h0000_0200, 4'd0, 32'h2222_2222, 32'h0);
    @(negedge clk);
    check_eq("b2b_addr_stable",  32'(dmem_addr), 32'h0000_0100);
    check_eq("b2b_wdata_stable", dmem_wdata, 32'h1111_1111);
    check_eq("b2b_stall",        32'(o_stall), 32'h1);
    dmem_ack   = 1'b1;
    dmem_rdata = 32'h55AA_55AA;
    @(negedge clk);
    dmem_ack = 1'b0;
    check_eq("b2b_resp_req",   32'(dmem_req), 32'h0);
    check_eq("b2b_wb_data",    o_wb_data, 32'h55AA_55AA);
    check_eq("b2b_wb_en",      32'(o_wb_en), 32'h1);
    @(negedge clk);
    check_eq("b2b_idle_req",   32'(dmem_req), 32'h0);
    @(negedge clk);
    nop();
    check_eq("b2b_req2",   32'(dmem_req), 32'h1);
    check_eq("b2b_we2",    32'(dmem_we), 32'h1);
    check_eq("b2b_addr2",  32'(dmem_addr), 32'h0000_0200);
    check_eq("b2b_wdata2", dmem_wdata, 32'h2222_2222);
    dmem_ack = 1'b1;
    @(negedge clk);
    dmem_ack = 1'b0;
    check_eq("b2b_st_wb_en", 32'(o_wb_en), 32'h0);
    @(negedge clk);

    // Read and write both set: handled as a read, mem_to_reg=0 returns alu
    drive(16'h0007, 32'h0000_0300, 4'd9, 32'h3333_3333, 32'h0);
    @(negedge clk);
    nop();
    check_eq("rw_we",  32'(dmem_we), 32'h0);
    check_eq("rw_req", 32'(dmem_req), 32'h1);
    dmem_ack   = 1'b1;
    dmem_rdata = 32'hFFFF_0000;
    @(negedge clk);
    dmem_ack = 1'b0;
    check_eq("rw_wb_en",   32'(o_wb_en), 32'h1);
    check_eq("rw_wb_data", o_wb_data, 32'h0000_0300);
    @(negedge clk);

    // Reset mid-ACCESS
    drive(16'h000D, 32'h0000_0040, 4'd4, 32'h0, 32'h0);
    @(negedge clk);
    nop();
    check_eq("mid_req_before", 32'(dmem_req), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("mid_req_async",   32'(dmem_req), 32'h0);
    check_eq("mid_stall_async", 32'(o_stall), 32'h0);
    check_eq("mid_wb_en_async", 32'(o_wb_en), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    wb_seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (o_wb_en || dmem_req) wb_seen++;
    end
    check_eq("mid_no_wb_after", 32'(wb_seen), 32'h0);

`ifdef MEM_TIMEOUT_EN
    // No ack ever: request held TIMEOUT cycles, then abandoned
    drive(16'h000D, 32'h0000_0044, 4'd6, 32'h0, 32'h0);
    req_cycles = 0;
    wb_seen    = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 0) nop();
      if (dmem_req) req_cycles++;
      if (o_wb_en) wb_seen++;
    end
    check_eq("to_req_cycles", 32'(req_cycles), 32'(TIMEOUT));
    check_eq("to_err",        32'(o_err), 32'h1);
    check_eq("to_no_wb",      32'(wb_seen), 32'h0);
    check_eq("to_stall",      32'(o_stall), 32'h0);
    drive(16'h0004, 32'h0000_0077, 4'd2, 32'h0, 32'h0);
    @(negedge clk);
    nop();
    check_eq("to_alu_wb_en",   32'(o_wb_en), 32'h1);
    check_eq("to_alu_wb_data", o_wb_data, 32'h0000_0077);
    check_eq("to_err_sticky",  32'(o_err), 32'h1);
`else
    // Without the timeout the access waits indefinitely
    drive(16'h000D, 32'h0000_0044, 4'd6, 32'h0, 32'h0);
    req_cycles = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 0) nop();
      if (dmem_req) req_cycles++;
    end
    check_eq("nto_req_cycles", 32'(req_cycles), 32'd20);
    check_eq("nto_stall",      32'(o_stall), 32'h1);
    check_eq("nto_err",        32'(o_err), 32'h0);
    dmem_ack   = 1'b1;
    dmem_rdata = 32'h0BAD_F00D;
    @(negedge clk);
    dmem_ack = 1'b0;
    check_eq("nto_wb_data", o_wb_data, 32'h0BAD_F00D);
    check_eq("nto_wb_en",   32'(o_wb_en), 32'h1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
